// File: rtl/gamepad_reader_if.sv
// Pad-side and console-side signals of the gamepad reader.
// master = the reader itself, slave = the pad/console environment around it.
interface gamepad_reader_if #(
    parameter int BUTTON_COUNT = 16
);
    logic                    poll_req;
    logic                    pad_data;
    logic                    pad_latch;
    logic                    pad_clk;
    logic [BUTTON_COUNT-1:0] buttons;
    logic                    buttons_valid;

    modport master (
        input  poll_req,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output buttons,
        output buttons_valid
    );

    modport slave (
        output poll_req,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  buttons,
        input  buttons_valid
    );
endinterface

// File: rtl/gamepad_reader.sv
// Polls an SNES-style pad (latch/clock/serial data) and presents an active-high button word.
// Latency: 2*HALF_PERIOD*(BUTTON_COUNT+1) + 1 cycles from LATCH entry to buttons_valid.
// Backpressure: none; buttons_valid is a one-cycle strobe and poll_req is only honoured in IDLE.
module gamepad_reader #(
    parameter int BUTTON_COUNT    = 16,
    parameter int HALF_PERIOD     = 150,
    parameter int POLL_PERIOD     = 416666,
    parameter int DATA_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
    gamepad_reader_if.master pad
);
    localparam int IDLE_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int PH_W   = $clog2(2 * HALF_PERIOD);
    localparam int IDX_W  = (BUTTON_COUNT > 1) ? $clog2(BUTTON_COUNT) : 1;
    localparam logic INV  = (DATA_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t                  state_q, state_nxt;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_nxt;
    logic [PH_W-1:0]         phase_q, phase_nxt;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_nxt;
    logic [BUTTON_COUNT-1:0] shift_q, shift_nxt;
    logic [BUTTON_COUNT-1:0] buttons_q, buttons_nxt;
    logic                    valid_q, valid_nxt;
    logic                    latch_q, latch_nxt;
    logic                    pclk_q, pclk_nxt;
    logic [1:0]              sync_q;
    logic                    sample_bit;

    assign sample_bit        = sync_q[1] ^ INV;
    assign pad.pad_latch     = latch_q;
    assign pad.pad_clk       = pclk_q;
    assign pad.buttons       = buttons_q;
    assign pad.buttons_valid = valid_q;

    always_comb begin
        state_nxt    = state_q;
        idle_cnt_nxt = idle_cnt_q;
        phase_nxt    = phase_q + 1'b1;
        bit_idx_nxt  = bit_idx_q;
        shift_nxt    = shift_q;
        buttons_nxt  = buttons_q;
        valid_nxt    = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_cnt_nxt = idle_cnt_q + 1'b1;
                phase_nxt    = '0;
                // Timer expiry and an explicit request coinciding still yield one poll.
                if (idle_cnt_q == IDLE_W'(POLL_PERIOD - 1) || pad.poll_req) begin
                    state_nxt    = S_LATCH;
                    idle_cnt_nxt = '0;
                end
            end
            S_LATCH: begin
                if (phase_q == PH_W'(2 * HALF_PERIOD - 1)) begin
                    state_nxt   = S_LOW;
                    phase_nxt   = '0;
                    bit_idx_nxt = '0;
                end
            end
            S_LOW: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    shift_nxt[bit_idx_q] = sample_bit;
                    state_nxt            = S_HIGH;
                    phase_nxt            = '0;
                end
            end
            S_HIGH: begin
                if (phase_q == PH_W'(HALF_PERIOD - 1)) begin
                    phase_nxt = '0;
                    if (bit_idx_q == IDX_W'(BUTTON_COUNT - 1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        bit_idx_nxt = bit_idx_q + 1'b1;
                        state_nxt   = S_LOW;
                    end
                end
            end
            S_DONE: begin
                buttons_nxt  = shift_q;
                valid_nxt    = 1'b1;
                state_nxt    = S_IDLE;
                idle_cnt_nxt = '0;
                phase_nxt    = '0;
            end
            default: begin
                state_nxt    = S_IDLE;
                idle_cnt_nxt = '0;
                phase_nxt    = '0;
            end
        endcase
        // Pad outputs follow the next state so they line up with the registered state.
        latch_nxt = (state_nxt == S_LATCH);
        pclk_nxt  = (state_nxt != S_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
            phase_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buttons_q  <= '0;
            valid_q    <= 1'b0;
            latch_q    <= 1'b0;
            pclk_q     <= 1'b1;
            sync_q     <= 2'b11;
        end else begin
            state_q    <= state_nxt;
            idle_cnt_q <= idle_cnt_nxt;
            phase_q    <= phase_nxt;
            bit_idx_q  <= bit_idx_nxt;
            shift_q    <= shift_nxt;
            buttons_q  <= buttons_nxt;
            valid_q    <= valid_nxt;
            latch_q    <= latch_nxt;
            pclk_q     <= pclk_nxt;
            sync_q     <= {sync_q[0], pad.pad_data};
        end
    end
endmodule

// File: doc/gamepad_reader.md
Name: gamepad_reader

Overview:
- Serial game-controller front end (SNES-style latch/clock/data shift protocol) that produces the 16-bit `buttons_in` word for the console top.
- Periodically latches the pad, shifts out N button bits, synchronises the raw serial data line and presents a stable, active-high parallel button word plus a one-cycle update strobe.
- Sits directly upstream of the console's button input; all button state changes seen by the CPU originate here.

Parameters:
- BUTTON_COUNT, 16, number of bits shifted per poll (width of `buttons`).
- HALF_PERIOD, 150, clk cycles per half bit period of `pad_clk` (6 us at 25 MHz); must be >= 2.
- POLL_PERIOD, 416666, idle clk cycles between end of one poll and start of the next (~60 Hz at 25 MHz); must be >= 1.
- DATA_ACTIVE_LOW, 1, 1 means the pad drives 0 for pressed; bits are inverted before storing.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- poll_req  in  1  request an immediate poll; honoured only in IDLE.
- pad_data  in  1  asynchronous raw serial data from the pad.
- pad_latch  out  1  latch strobe to the pad, active high.
- pad_clk  out  1  shift clock to the pad, idles high.
- buttons  out  BUTTON_COUNT  last complete button word, bit i = button i, 1 = pressed.
- buttons_valid  out  1  one-cycle pulse when `buttons` is updated.

Behaviour:
- `pad_data` passes through a 2-flop synchroniser; only the synchronised value is sampled.
- Reset (sync, high): state=IDLE, idle counter=0, pad_latch=0, pad_clk=1, buttons=0, buttons_valid=0, synchroniser flops=1. Reset during any state aborts the poll immediately; no partial word is ever written to `buttons`.
- Outputs pad_latch, pad_clk, buttons and buttons_valid are registered.
- IDLE:
  - pad_latch=0, pad_clk=1; counter increments each cycle.
  - Go to LATCH when counter == POLL_PERIOD-1 or poll_req=1 (either suffices; simultaneous = single poll); counter clears on exit.
  - First automatic poll: LATCH entered on cycle POLL_PERIOD after reset deasserts.
- LATCH: pad_latch=1, pad_clk=1 for exactly 2*HALF_PERIOD cycles, then go LOW with bit index=0.
- LOW:
  - pad_clk=0 for HALF_PERIOD cycles.
  - On the last cycle, sample the synchronised data into shift bit[index], inverted if DATA_ACTIVE_LOW.
  - Then go HIGH.
- HIGH:
  - pad_clk=1 for HALF_PERIOD cycles.
  - On the last cycle, if index == BUTTON_COUNT-1 go DONE, else index+1 and go LOW.
- DONE: for one cycle, copy the shift register to `buttons`; buttons_valid=1 in that same cycle (visible on the next edge's register outputs). Then go IDLE with counter=0.
- Timing: LATCH entry to buttons_valid high = 2*HALF_PERIOD + 2*HALF_PERIOD*BUTTON_COUNT + 1 cycles (5101 with defaults).
- poll_req outside IDLE is ignored; it is not queued.
- `buttons` holds its value between polls; identical consecutive words still pulse buttons_valid.
- Counter widths are $clog2 of their maxima; no wrap-around occurs within legal parameters.
- Pad unplugged (data floats high, active-low): buttons=0.

Test Plan:
- Use HALF_PERIOD=2, POLL_PERIOD=20, BUTTON_COUNT=16, DATA_ACTIVE_LOW=1 throughout.
- Reset, hold pad_data=1 -> outputs at reset values; LATCH on cycle 20; buttons_valid pulses 69 cycles after LATCH entry; buttons=0x0000.
- Pad model shifting 16'hA5C3 inverted (bit 0 first, advancing on pad_clk rising edge) -> buttons=16'hA5C3 with one valid pulse; pad_latch high exactly 4 cycles; exactly 16 pad_clk low pulses, each 2 cycles.
- poll_req=1 at cycle 5 in IDLE -> LATCH on the next cycle; poll_req asserted during the HIGH state -> no extra poll, next poll 20 cycles after DONE.
- Reset asserted mid-shift (after 7 bits) with prior buttons=0x00FF -> buttons=0, pad_clk=1, pad_latch=0 next cycle; no valid pulse; a fresh poll completes correctly afterwards.
- pad_data toggled between sample points only -> stored bits match the values present at LOW-phase ends; DATA_ACTIVE_LOW=0 build with 0xA5C3 driven non-inverted -> buttons=0xA5C3.
